// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
  localparam int          DEF_ADDR_W    = 32;
  localparam int          DEF_MEM_DEPTH = 1024;
  localparam int          DEF_RESET_PC  = 0;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: control in, instruction memory port, IF/ID register and status out.
interface fetch_if #(
  parameter int ADDR_W = 32
);

  logic              stall_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_target_i;
  logic              halt_i;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_instr_i;
  logic [31:0]       ifid_instr_o;
  logic [ADDR_W-1:0] ifid_pc_plus1_o;
  logic              ifid_valid_o;
  logic              halted_o;
  logic              fault_o;

  modport master (
    input  stall_i, redirect_i, redirect_target_i, halt_i, imem_instr_i,
    output imem_addr_o, ifid_instr_o, ifid_pc_plus1_o, ifid_valid_o, halted_o, fault_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_target_i, halt_i, imem_instr_i,
    input  imem_addr_o, ifid_instr_o, ifid_pc_plus1_o, ifid_valid_o, halted_o, fault_o
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register with prioritised next-PC selection (halt, fault, redirect, stall, +1).
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                MEM_DEPTH = DEF_MEM_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              halt,
  input  logic              redirect,
  input  logic              stall,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              out_of_range
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  logic [ADDR_W-1:0] pc_d;

  assign pc_plus1     = pc + 1'b1;
  assign out_of_range = {1'b0, pc} >= DEPTH;

  // Outside RUN the PC is frozen, which covers both the BOOT cycle and HALTED.
  always_comb begin
    pc_d = pc;
    if (run && !halt && !out_of_range) begin
      if (redirect)
        pc_d = target;
      else if (!stall)
        pc_d = pc_plus1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= RESET_PC;
    else
      pc <= pc_d;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: BOOT/RUN/HALTED control, IF/ID register and sticky fault flag.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                MEM_DEPTH = DEF_MEM_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC)
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc, pc_plus1;
  logic              out_of_range;
  logic              capture, flush, set_fault;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] pp1_q;
  logic              valid_q, fault_q;

  fetch_pc_reg #(
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH),
    .RESET_PC  (RESET_PC)
  ) u_pc (
    .clk          (clk),
    .rst          (rst),
    .run          (state_q == RUN),
    .halt         (bus.halt_i),
    .redirect     (bus.redirect_i),
    .stall        (bus.stall_i),
    .target       (bus.redirect_target_i),
    .pc           (pc),
    .pc_plus1     (pc_plus1),
    .out_of_range (out_of_range)
  );

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    flush     = 1'b0;
    set_fault = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.halt_i) begin
          state_d = HALTED;
          flush   = 1'b1;
        end else if (out_of_range) begin
          state_d   = HALTED;
          flush     = 1'b1;
          set_fault = 1'b1;
        end else if (bus.redirect_i) begin
          flush = 1'b1;
        end else if (!bus.stall_i) begin
          capture = 1'b1;
        end
      end
      HALTED:  flush   = 1'b1;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= BOOT;
    else
      state_q <= state_d;
  end

  // Memory data is sampled only on a real fetch, so X words never enter IF/ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pp1_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (capture) begin
        instr_q <= bus.imem_instr_i;
        pp1_q   <= pc_plus1;
        valid_q <= 1'b1;
      end else if (flush) begin
        valid_q <= 1'b0;
      end
      if (set_fault)
        fault_q <= 1'b1;
    end
  end

  assign bus.imem_addr_o     = pc;
  assign bus.ifid_instr_o    = instr_q;
  assign bus.ifid_pc_plus1_o = pp1_q;
  assign bus.ifid_valid_o    = valid_q;
  assign bus.halted_o        = (state_q == HALTED);
  assign bus.fault_o         = fault_q;

endmodule
